// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared-multiplier controller:
// FSM state encoding, default settle time and settle counter width.
package mult_share_pkg;

    localparam int unsigned SETTLE_DEFAULT = 2;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // The counter counts down to zero inclusive, so it starts one below the cycle count.
    function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
        return CNT_W'(settle - 1);
    endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Signal bundle between two requesters, the shared multiplier and the controller.
interface mult_share_ctrl_if;

    // Handshake: each requester runs a 4-phase protocol. It raises reqN with
    // stable operands, waits for ackN high (product valid while ackN is high),
    // drops reqN, and the controller drops ackN on the edge that sees reqN low.
    // A req that falls before ack rises still gets a single-cycle ack.
    logic        req0;
    logic        req1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        ack0;
    logic        ack1;
    logic [15:0] product;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        busy;
    logic        gnt;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_p,
        output ack0, ack1, product, mul_a, mul_b, busy, gnt
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_p,
        input  ack0, ack1, product, mul_a, mul_b, busy, gnt
    );

endinterface

// File: rtl/mult_rr_pick.sv
// Two-way round-robin pick: pointer names the requester favoured on a tie.
module mult_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = pointer;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Arbitrated front end for one external 8x8 multiplier: grants one of two
// 4-phase requesters, waits SETTLE cycles, registers the product and acks.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic             Clock,
    input  logic             Resetn,
    mult_share_ctrl_if.slave bus,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = settle_load(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             ptr;
    logic             ptr_nx;
    logic             gnt_q;
    logic             gnt_nx;
    logic             ack0_q;
    logic             ack0_nx;
    logic             ack1_q;
    logic             ack1_nx;
    logic [15:0]      product_q;
    logic [15:0]      product_nx;
    logic [7:0]       mul_a_q;
    logic [7:0]       mul_a_nx;
    logic [7:0]       mul_b_q;
    logic [7:0]       mul_b_nx;

    logic             pick_winner;
    logic             pick_valid;
    logic             req_granted;
    logic             ack_hold;

    mult_rr_pick u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .pointer (ptr),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    assign req_granted = gnt_q ? bus.req1 : bus.req0;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ptr_nx     = ptr;
        gnt_nx     = gnt_q;
        ack0_nx    = 1'b0;
        ack1_nx    = 1'b0;
        product_nx = product_q;
        mul_a_nx   = mul_a_q;
        mul_b_nx   = mul_b_q;
        ack_hold   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_nx   = pick_winner;
                    mul_a_nx = pick_winner ? bus.a1 : bus.a0;
                    mul_b_nx = pick_winner ? bus.b1 : bus.b0;
                    cnt_nx   = CNT_LOAD;
                    state_nx = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nx = ST_CAPTURE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end

            ST_CAPTURE: begin
                product_nx = bus.mul_p;
                state_nx   = ST_ACK;
            end

            ST_ACK: begin
                // The first ACK cycle always raises ack, so a requester that
                // already let go still sees exactly one ack pulse.
                ack_hold = req_granted || !(ack0_q || ack1_q);
                ack0_nx  = ack_hold && !gnt_q;
                ack1_nx  = ack_hold && gnt_q;
                if (!req_granted) begin
                    ptr_nx   = ~gnt_q;
                    state_nx = ST_IDLE;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= 1'b0;
            gnt_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            product_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            gnt_q     <= gnt_nx;
            ack0_q    <= ack0_nx;
            ack1_q    <= ack1_nx;
            product_q <= product_nx;
            mul_a_q   <= mul_a_nx;
            mul_b_q   <= mul_b_nx;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.product = product_q;
    assign bus.mul_a   = mul_a_q;
    assign bus.mul_b   = mul_b_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state != ST_IDLE);
    assign dbg_state   = state;

endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving the multiplier settle cycles (legal 1..15).
REQ-002 SHALL have port Clock, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0 and req1, input, 1 each, requester 0/1 request (4-phase handshake).
REQ-005 SHALL have ports a0, b0, a1, b1, input, 8 each, requester 0/1 unsigned operands.
REQ-006 SHALL have ports ack0 and ack1, output, 1 each, requester 0/1 acknowledge; product valid while high.
REQ-007 SHALL have port product, output, 16, the registered result of the last completed operation.
REQ-008 SHALL have ports mul_a and mul_b, output, 8 each, the registered operands driven to the shared combinational 8x8 multiplier.
REQ-009 SHALL have port mul_p, input, 16, the shared multiplier's product.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port gnt, output, 1, the index of the requester currently or last served.

Function
REQ-012 SHALL implement the states IDLE, SETTLE, CAPTURE and ACK.
REQ-013 In IDLE with any req high, SHALL select the winner, load its a/b into mul_a/mul_b, set gnt, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; with one request high, that requester wins.
REQ-015 SETTLE SHALL last exactly SETTLE cycles (counter decrements to 0), then go to CAPTURE.
REQ-016 CAPTURE SHALL register mul_p into product in one cycle, then go to ACK.
REQ-017 In ACK, the ack of gnt SHALL be high and the other ack low; ACK SHALL exit to IDLE on the first cycle the granted req is sampled low.
REQ-018 ACK SHALL be registered, rising exactly SETTLE+2 edges after the edge that sampled the winning req in IDLE.
REQ-019 If the granted req is already low on entry to ACK, SHALL assert ack for one cycle and return to IDLE.
REQ-020 A granted req dropping during SETTLE or CAPTURE SHALL NOT abort the operation; product SHALL still update.
REQ-021 Operand changes after grant SHALL be ignored; mul_a and mul_b SHALL hold until the next grant.
REQ-022 The round-robin pointer SHALL toggle to the non-served requester on exit from ACK.
REQ-023 A request from the non-granted requester during an operation SHALL be held pending and served next.
REQ-024 product SHALL hold its value through IDLE and change only in CAPTURE; no truncation is permitted (full 16 bits).
REQ-025 Returning from ACK to IDLE SHALL cost one cycle; a pending request is sampled in that IDLE cycle.

Reset
REQ-026 Resetn low SHALL force, asynchronously, state IDLE, ack0=ack1=0, product=0, mul_a=mul_b=0, gnt=0, counter=0 and pointer favouring requester 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no ack; first-after-reset arbitration SHALL favour requester 0.

Structure
REQ-028 The state encoding, the SETTLE default and the counter width (4) SHALL live in a shared package, mult_share_pkg.
REQ-029 The multiplier SHALL stay outside this block; the round-robin pick logic SHALL be the single sub-module mult_rr_pick (inputs req0, req1, pointer; output winner, valid).

Verification
REQ-030 SHALL cover req0 only, with a0=0xFF, b0=0xFF and SETTLE=2: ack0 high at edge 4 after sampling, product=0xFE01, ack1 stays 0.
REQ-031 SHALL cover req0 and req1 raised together after reset, with a0=12, b0=10, a1=3, b1=5: first ack0 with product 0x0078, then ack1 with product 0x000F.
REQ-032 SHALL cover req0 re-raised immediately while req1 is held: grants alternate 0,1,0; no requester is served twice in a row while the other waits.
REQ-033 SHALL cover Resetn pulsed low during SETTLE: all outputs 0 at once, no ack; the next simultaneous request goes to requester 0.
REQ-034 SHALL cover req1 dropped during SETTLE: product still updates and ack1 is high for exactly one cycle.
REQ-035 SHALL cover a0/b0 changed to 0x00 during SETTLE after a grant with 0x10 x 0x10: product=0x0100.
